pipe_stage_elastic: RTL and testbench

// - Generic parametrised pipeline-stage register replacing the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches.
// - Adds valid/ready handshaking, an optional 2-entry skid buffer, synchronous flush and bubble insertion.
// - A bubble forces all control bits to 0, so it never writes the register file or memory.
// - Carries a saturating stall-cycle counter for performance analysis; one instance sits between each pair of stages.

---
 rtl/pipe_stage_elastic_pkg.sv | 20 ++
 rtl/pipe_stage_elastic_sat_counter.sv | 26 ++
 rtl/pipe_stage_elastic.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared control-bit layout and per-stage payload widths for the elastic
// pipeline-stage registers.
package pipe_pkg;

    localparam int CTRL_REGW      = 0;
    localparam int CTRL_MEMTOREG  = 1;
    localparam int CTRL_MEMW      = 2;
    localparam int CTRL_MEMR      = 3;
    localparam int CTRL_BRANCH    = 4;
    localparam int CTRL_ALUSRC    = 5;
    localparam int CTRL_ALUOP_LSB = 6;
    localparam int CTRL_ALUOP_MSB = 7;

    // Caller-packed payload widths for each inter-stage boundary.
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_DATA_W  = 160;
    localparam int EXMEM_DATA_W = 128;
    localparam int MEMWB_DATA_W = 96;

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter with synchronous clear that overrides increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count register: clear wins, then increment until the ceiling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= {CNT_W{1'b0}};
        end else if (clr) begin
            count <= {CNT_W{1'b0}};
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready handshake, optional 2-entry
// skid buffer, flush, bubble-gated control bits and a stall counter.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = IFID_DATA_W,
    parameter int CTRL_W = CTRL_ALUOP_MSB + 1,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid;
    logic              skid_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic deliver;
    logic main_valid_nxt;
    logic skid_valid_nxt;
    logic load_main;
    logic main_from_skid;
    logic load_skid;

    assign accept  = in_valid & in_ready;
    assign deliver = main_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            // in_ready depends only on held state, so no out_ready->in_ready path.
            assign in_ready = ~skid_valid;

            // Two-entry steering; skid always holds the younger beat.
            always_comb begin
                main_valid_nxt = main_valid;
                skid_valid_nxt = skid_valid;
                load_main      = 1'b0;
                main_from_skid = 1'b0;
                load_skid      = 1'b0;
                if (flush) begin
                    main_valid_nxt = 1'b0;
                    skid_valid_nxt = 1'b0;
                end else if (deliver) begin
                    if (skid_valid) begin
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                        main_valid_nxt = 1'b1;
                        load_skid      = accept;
                        skid_valid_nxt = accept;
                    end else begin
                        load_main      = accept;
                        main_valid_nxt = accept;
                    end
                end else if (accept) begin
                    if (main_valid) begin
                        load_skid      = 1'b1;
                        skid_valid_nxt = 1'b1;
                    end else begin
                        load_main      = 1'b1;
                        main_valid_nxt = 1'b1;
                    end
                end else begin
                    main_valid_nxt = main_valid;
                    skid_valid_nxt = skid_valid;
                end
            end
        end else begin : g_single
            assign in_ready = out_ready | ~main_valid;

            // Single entry: refill on accept, drain on deliver.
            always_comb begin
                main_valid_nxt = main_valid;
                skid_valid_nxt = 1'b0;
                load_main      = 1'b0;
                main_from_skid = 1'b0;
                load_skid      = 1'b0;
                if (flush) begin
                    main_valid_nxt = 1'b0;
                end else begin
                    load_main      = accept;
                    main_valid_nxt = accept | (main_valid & ~deliver);
                end
            end
        end
    endgenerate

    // Entry state; payload registers only move on their load enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= {CTRL_W{1'b0}};
            main_data  <= {DATA_W{1'b0}};
            skid_ctrl  <= {CTRL_W{1'b0}};
            skid_data  <= {DATA_W{1'b0}};
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            if (load_main) begin
                main_ctrl <= main_from_skid ? skid_ctrl : in_ctrl;
                main_data <= main_from_skid ? skid_data : in_data;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    // Bubble gating: an empty stage can never present a live control bit.
    assign out_ctrl  = main_valid ? main_ctrl : {CTRL_W{1'b0}};
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (main_valid & ~out_ready),
        .clr   (stat_clr),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: skid (u_dut1) and single-entry
// (u_dut0) variants driven from the same upstream/downstream signals.
module tb_pipe_stage_elastic;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              out_ready;
    logic              stat_clr;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;

    logic              in_ready1, out_valid1, in_ready0, out_valid0;
    logic [CTRL_W-1:0] out_ctrl1, out_ctrl0;
    logic [DATA_W-1:0] out_data1, out_data0;
    logic [1:0]        occ1, occ0;
    logic [CNT_W-1:0]  cnt1, cnt0;

    int checks = 0;
    int errors = 0;
    logic prev;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occ1), .stat_clr(stat_clr),
        .stall_cnt(cnt1)
    );

    pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0), .CNT_W(CNT_W)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occ0), .stat_clr(stat_clr),
        .stall_cnt(cnt0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stat_clr = 1'b0;
        in_ctrl = 8'h00; in_data = 64'h0;
        @(negedge clk); @(negedge clk);
        chk("rst_valid1", out_valid1, 64'h0);
        chk("rst_ctrl1", out_ctrl1, 64'h0);
        chk("rst_data1", out_data1, 64'h0);
        chk("rst_occ1", occ1, 64'h0);
        chk("rst_cnt1", cnt1, 64'h0);
        chk("rst_ready1", in_ready1, 64'h1);
        chk("rst_ready0", in_ready0, 64'h1);
        chk("rst_valid0", out_valid0, 64'h0);
        reset = 1'b0;

        // Streaming 1..100 back-to-back, one-cycle latency
        out_ready = 1'b1; in_ctrl = 8'h5A;
        for (int i = 1; i <= 101; i++) begin
            @(negedge clk);
            if (i > 1) begin
                chk("stream_valid1", out_valid1, 64'h1);
                chk("stream_data1", out_data1, 64'(i - 1));
                chk("stream_ctrl1", out_ctrl1, 64'h5A);
                chk("stream_ready1", in_ready1, 64'h1);
                chk("stream_valid0", out_valid0, 64'h1);
                chk("stream_data0", out_data0, 64'(i - 1));
            end
            if (i <= 100) begin
                in_valid = 1'b1; in_data = 64'(i);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("drain_valid1", out_valid1, 64'h0);
        chk("drain_ctrl1", out_ctrl1, 64'h0);
        chk("drain_occ1", occ1, 64'h0);
        chk("drain_valid0", out_valid0, 64'h0);

        // Bubble gating with in_ctrl all ones
        in_ctrl = 8'hFF; prev = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("bub_valid1", out_valid1, 64'(prev));
            chk("bub_ctrl1", out_ctrl1, prev ? 64'hFF : 64'h00);
            chk("bub_ctrl0", out_ctrl0, prev ? 64'hFF : 64'h00);
            in_valid = ((k % 2) == 0); in_data = 64'(200 + k);
            prev = in_valid;
        end
        @(negedge clk);
        chk("bub_end_valid1", out_valid1, 64'h0);

        // Backpressure: A in main, B into skid, C held upstream
        in_ctrl = 8'h11; in_valid = 1'b1; in_data = 64'hA; out_ready = 1'b0;
        @(negedge clk);
        chk("bp_a_data1", out_data1, 64'hA);
        chk("bp_a_occ1", occ1, 64'h1);
        chk("bp_a_ready1", in_ready1, 64'h1);
        chk("bp_a_ready0", in_ready0, 64'h0);
        in_data = 64'hB;
        @(negedge clk);
        chk("bp_b_occ1", occ1, 64'h2);
        chk("bp_b_ready1", in_ready1, 64'h0);
        chk("bp_b_data1", out_data1, 64'hA);
        in_data = 64'hC;
        @(negedge clk);
        chk("bp_c_occ1", occ1, 64'h2);
        chk("bp_c_ready1", in_ready1, 64'h0);
        chk("bp_c_data1", out_data1, 64'hA);
        chk("bp_c_data0", out_data0, 64'hA);
        chk("bp_c_occ0", occ0, 64'h1);
        out_ready = 1'b1;
        #1;
        chk("bp_comb_ready0", in_ready0, 64'h1);
        chk("bp_reg_ready1", in_ready1, 64'h0);
        @(negedge clk);
        chk("bp_rel_b_data1", out_data1, 64'hB);
        chk("bp_rel_b_occ1", occ1, 64'h1);
        chk("bp_rel_ready1", in_ready1, 64'h1);
        chk("bp_rel_c_data0", out_data0, 64'hC);
        @(negedge clk);
        chk("bp_rel_c_data1", out_data1, 64'hC);
        chk("bp_rel_c_valid1", out_valid1, 64'h1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_empty_valid1", out_valid1, 64'h0);

        // Flush with two beats held plus one offered
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hD;
        @(negedge clk);
        in_data = 64'hE;
        @(negedge clk);
        chk("fl_pre_occ1", occ1, 64'h2);
        in_data = 64'hF; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid1", out_valid1, 64'h0);
        chk("fl_ctrl1", out_ctrl1, 64'h0);
        chk("fl_occ1", occ1, 64'h0);
        chk("fl_ready1", in_ready1, 64'h1);
        chk("fl_valid0", out_valid0, 64'h0);
        chk("fl_ctrl0", out_ctrl0, 64'h0);
        chk("fl_occ0", occ0, 64'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fl_gone_valid1", out_valid1, 64'h0);
        end
        in_valid = 1'b1; in_data = 64'h6; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_acc_valid1", out_valid1, 64'h0);
        chk("fl_acc_occ1", occ1, 64'h0);
        chk("fl_acc_valid0", out_valid0, 64'h0);
        @(negedge clk);
        chk("fl_acc_later1", out_valid1, 64'h0);

        // Asynchronous reset with two beats held
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h77;
        @(negedge clk);
        in_data = 64'h88;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_pre_occ1", occ1, 64'h2);
        #2 reset = 1'b1;
        #1;
        chk("mr_valid1", out_valid1, 64'h0);
        chk("mr_ctrl1", out_ctrl1, 64'h0);
        chk("mr_occ1", occ1, 64'h0);
        chk("mr_cnt1", cnt1, 64'h0);
        chk("mr_data1", out_data1, 64'h0);
        chk("mr_valid0", out_valid0, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_ready1", in_ready1, 64'h1);
        chk("mr_ready0", in_ready0, 64'h1);

        // Stall counter saturation, clear and flush independence
        in_valid = 1'b1; in_data = 64'h99; in_ctrl = 8'h22;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("cnt_sat1", cnt1, (k - 1 > 15) ? 64'd15 : 64'(k - 1));
            chk("cnt_sat0", cnt0, (k - 1 > 15) ? 64'd15 : 64'(k - 1));
            if (k == 1) in_valid = 1'b0;
        end
        stat_clr = 1'b1;
        @(negedge clk);
        chk("cnt_clr1", cnt1, 64'h0);
        chk("cnt_clr0", cnt0, 64'h0);
        stat_clr = 1'b0;
        @(negedge clk);
        chk("cnt_resume1", cnt1, 64'h1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("cnt_flush1", cnt1, 64'h2);
        chk("cnt_flush_valid1", out_valid1, 64'h0);
        @(negedge clk);
        chk("cnt_hold1", cnt1, 64'h2);
        chk("cnt_hold0", cnt0, 64'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
